// File: rtl/if_fetch_buffer.sv
// rtl/if_fetch_buffer.sv - byte-serial instruction fetch with prefetch FIFO
// Assembles little-endian words from a byte RAM and queues {word, pc} for IF/ID.
module if_fetch_buffer #(
  parameter int ADDR_W = 32,
  parameter int INST_BYTES = 4,
  parameter int DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  output logic [ADDR_W-1:0]       addr_RAM_o,
  output logic                    rden_RAM_o,
  input  logic [7:0]              data_RAM_i,
  input  logic                    stall_RAM_i,
  input  logic                    redirect_i,
  input  logic [ADDR_W-1:0]       redirect_pc_i,
  output logic                    inst_valid_o,
  output logic [8*INST_BYTES-1:0] inst_o,
  output logic [ADDR_W-1:0]       inst_pc_o,
  input  logic                    inst_ready_i
);

  localparam int IW = 8 * INST_BYTES;
  localparam int KW = $clog2(INST_BYTES);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC & PC_MASK;
  localparam logic [KW-1:0] K_LAST = KW'(INST_BYTES - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST} state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [IW-1:0]     word_q, word_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     fifo_inst_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q [DEPTH];

  logic          head_valid, flush, pop, push;
  logic [CW-1:0] cnt_after_pop;
  logic [IW-1:0] push_word;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_valid    = (cnt_q != '0);
  assign flush         = rdy & redirect_i;
  assign pop           = rdy & head_valid & inst_ready_i & ~redirect_i;
  assign cnt_after_pop = cnt_q - CW'(pop);
  assign push_word     = {data_RAM_i, word_q[IW-9:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      k_q      <= '0;
      pc_q     <= RESET_PC_A;
      word_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      pc_q     <= pc_d;
      word_q   <= word_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        fifo_inst_q[wr_ptr_q] <= push_word;
        fifo_pc_q[wr_ptr_q]   <= pc_q;
      end
    end
  end

  // A pause loses the byte in flight, so any word in progress restarts at byte 0.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pc_d    = pc_q;
    word_d  = word_q;
    push    = 1'b0;
    if (!rdy) begin
      if (state_q != S_IDLE) begin
        state_d = S_FETCH;
        k_d     = '0;
        word_d  = '0;
      end
    end else if (redirect_i) begin
      state_d = S_FETCH;
      k_d     = '0;
      pc_d    = redirect_pc_i & PC_MASK;
      word_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cnt_after_pop < DEPTH_C) begin
            state_d = S_FETCH;
            k_d     = '0;
          end
        end
        S_FETCH: begin
          if (stall_RAM_i) begin
            k_d    = '0;
            word_d = '0;
          end else begin
            for (int b = 0; b < INST_BYTES - 1; b++) begin
              if (k_q == KW'(b + 1)) word_d[8*b +: 8] = data_RAM_i;
            end
            if (k_q == K_LAST) begin
              state_d = S_LAST;
              k_d     = '0;
            end else begin
              k_d = k_q + KW'(1);
            end
          end
        end
        S_LAST: begin
          k_d    = '0;
          word_d = '0;
          if (stall_RAM_i) begin
            state_d = S_FETCH;
          end else begin
            push    = 1'b1;
            pc_d    = pc_q + ADDR_W'(INST_BYTES);
            state_d = ((cnt_after_pop + CW'(1)) < DEPTH_C) ? S_FETCH : S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          k_d     = '0;
        end
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    rden_RAM_o   = rdy & ~rst & (state_q == S_FETCH);
    addr_RAM_o   = rst ? RESET_PC_A : pc_q + ADDR_W'(k_q);
    inst_valid_o = ~rst & head_valid;
    inst_o       = '0;
    inst_pc_o    = '0;
    if (~rst & head_valid) begin
      inst_o    = fifo_inst_q[rd_ptr_q];
      inst_pc_o = fifo_pc_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb/tb_if_fetch_buffer.sv - self-checking bench for if_fetch_buffer
// Directed timelines plus a FIFO-order/RAM-content model checked every cycle.
module tb_if_fetch_buffer;

  logic        clk, rst, rdy, redirect, stall, inst_ready;
  logic [31:0] redirect_pc;

  logic [31:0] addr_a, inst_a, pc_a;
  logic        rden_a, valid_a;
  logic [7:0]  data_a;

  logic [31:0] addr_b, pc_b;
  logic [15:0] inst_b;
  logic        rden_b, valid_b;
  logic [7:0]  data_b;

  logic [7:0]  ram   [0:511];
  logic [7:0]  ram_b [0:15];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_pc, prev_addr;
  logic        redir_seen, prev_rden;

  if_fetch_buffer #(.ADDR_W(32), .INST_BYTES(4), .DEPTH(2), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .rst(rst), .rdy(rdy),
    .addr_RAM_o(addr_a), .rden_RAM_o(rden_a), .data_RAM_i(data_a), .stall_RAM_i(stall),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .inst_valid_o(valid_a), .inst_o(inst_a), .inst_pc_o(pc_a), .inst_ready_i(inst_ready)
  );

  if_fetch_buffer #(.ADDR_W(32), .INST_BYTES(2), .DEPTH(2), .RESET_PC(32'h0)) dut_b (
    .clk(clk), .rst(rst), .rdy(rdy),
    .addr_RAM_o(addr_b), .rden_RAM_o(rden_b), .data_RAM_i(data_b), .stall_RAM_i(1'b0),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .inst_valid_o(valid_b), .inst_o(inst_b), .inst_pc_o(pc_b), .inst_ready_i(inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    data_a <= ram[addr_a[8:0]];
    data_b <= ram_b[addr_b[3:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] x;
    for (int b = 0; b < 4; b++) begin
      x = a + 32'(b);
      w[8*b +: 8] = ram[x[8:0]];
    end
    return w;
  endfunction

  // Head of the queue must always be the next pc in program order since the last redirect.
  always @(posedge clk) begin
    prev_rden <= rden_a & ~rst;
    prev_addr <= addr_a;
    if (rst) begin
      exp_pc     <= 32'h0;
      redir_seen <= 1'b0;
    end else begin
      redir_seen <= rdy & redirect;
      if (rdy & redirect)                  exp_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (valid_a & inst_ready & rdy) exp_pc <= exp_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (redir_seen) chk("flush_valid", valid_a, 1'b0);
      if (valid_a) begin
        chk("head_pc", pc_a, exp_pc);
        chk("head_inst", inst_a, ram_word(exp_pc));
      end
      if (rden_a && addr_a[1:0] != 2'b00) begin
        chk("addr_seq_prev_rden", prev_rden, 1'b1);
        chk("addr_seq", addr_a, prev_addr + 32'd1);
      end
      if (!rdy) chk("pause_rden", rden_a, 1'b0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1; rdy = 1'b1; redirect = 1'b0; stall = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    chk("rst_rden", rden_a, 1'b0);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_inst", inst_a, 32'h0);
    chk("rst_pc", pc_a, 32'h0);
    chk("rst_addr", addr_a, 32'h0);
    chk("rst_valid_b", valid_b, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  int t3_addr [7] = '{0, 1, 2, 0, 1, 2, 3};

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'(i * 7 + 3);
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;
    for (int i = 0; i < 16; i++) ram_b[i] = 8'(i);
    ram_b[0] = 8'hAB; ram_b[1] = 8'hCD;
    rst = 1'b1; rdy = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0; inst_ready = 1'b0;

    // First word out of reset, both widths
    do_reset();
    inst_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      if (c < 4) begin
        chk("t1_rden", rden_a, 1'b1);
        chk("t1_addr", addr_a, 32'(c));
      end
      if (c == 4) chk("t1_last_rden", rden_a, 1'b0);
      if (c == 5) begin
        chk("t1_valid", valid_a, 1'b1);
        chk("t1_inst", inst_a, 32'h0000_0513);
        chk("t1_pc", pc_a, 32'h0);
        chk("t1_next_addr", addr_a, 32'h4);
        chk("t1_next_rden", rden_a, 1'b1);
      end
      if (c < 2) begin
        chk("b_rden", rden_b, 1'b1);
        chk("b_addr", addr_b, 32'(c));
      end
      if (c == 2) chk("b_last_rden", rden_b, 1'b0);
      if (c == 3) begin
        chk("b_valid", valid_b, 1'b1);
        chk("b_inst", inst_b, 16'hCDAB);
        chk("b_pc", pc_b, 32'h0);
        chk("b_next_addr", addr_b, 32'h2);
      end
    end

    // FIFO fills to DEPTH, then one pop restarts fetch
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c > 0) next_cycle();
      inst_ready = (c == 12);
      @(negedge clk);
      if (c >= 10 && c <= 12) begin
        chk("t2_full_rden", rden_a, 1'b0);
        chk("t2_full_valid", valid_a, 1'b1);
        chk("t2_full_pc", pc_a, 32'h0);
      end
      if (c == 13) begin
        chk("t2_rden", rden_a, 1'b1);
        chk("t2_addr", addr_a, 32'h8);
        chk("t2_head_pc", pc_a, 32'h4);
      end
    end

    // RAM stall on byte 2 retries the same word
    do_reset();
    inst_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      stall = (c == 2);
      @(negedge clk);
      if (c <= 6) begin
        chk("t3_rden", rden_a, 1'b1);
        chk("t3_addr", addr_a, 32'(t3_addr[c]));
      end
      if (c >= 3 && c <= 7) chk("t3_no_early_valid", valid_a, 1'b0);
      if (c == 7) chk("t3_last_rden", rden_a, 1'b0);
      if (c == 8) begin
        chk("t3_valid", valid_a, 1'b1);
        chk("t3_inst", inst_a, 32'h0000_0513);
        chk("t3_pc", pc_a, 32'h0);
      end
      if (c == 9) chk("t3_no_garbage", valid_a, 1'b0);
    end

    // Redirect flushes a full FIFO
    do_reset();
    redirect_pc = 32'h0000_0103;
    for (int c = 0; c < 17; c++) begin
      if (c > 0) next_cycle();
      redirect = (c == 10);
      @(negedge clk);
      if (c == 10) chk("t4_pre_valid", valid_a, 1'b1);
      if (c == 11) begin
        chk("t4_flush_valid", valid_a, 1'b0);
        chk("t4_rden", rden_a, 1'b1);
        chk("t4_addr", addr_a, 32'h100);
      end
      if (c == 15) chk("t4_last_valid", valid_a, 1'b0);
      if (c == 16) begin
        chk("t4_valid", valid_a, 1'b1);
        chk("t4_pc", pc_a, 32'h100);
        chk("t4_inst", inst_a, 32'h1811_0A03);
      end
    end

    // rdy pause while addressing byte 1
    do_reset();
    inst_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      rdy = !(c >= 1 && c <= 3);
      @(negedge clk);
      if (c == 0) chk("t5_addr0", addr_a, 32'h0);
      if (c >= 1 && c <= 3) begin
        chk("t5_pause_rden", rden_a, 1'b0);
        chk("t5_pause_valid", valid_a, 1'b0);
      end
      if (c >= 4 && c <= 7) begin
        chk("t5_rden", rden_a, 1'b1);
        chk("t5_addr", addr_a, 32'(c - 4));
      end
      if (c == 8) chk("t5_last_rden", rden_a, 1'b0);
      if (c == 9) begin
        chk("t5_valid", valid_a, 1'b1);
        chk("t5_inst", inst_a, 32'h0000_0513);
        chk("t5_pc", pc_a, 32'h0);
      end
    end

    next_cycle();
    next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
